// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
//   Shared types and the decode function for decoder_pipe.
//   - mode_e    : MODE_ONEHOT (0) sets a single line, MODE_THERM (1) sets
//                 every line from 0 up to and including the select.
//   - STAT_W    : width of the optional delivered-word/error counters.
//   - DEC_MAX_W : widest decode the function supports. NUM_OUT must not
//                 exceed this value.
//   - decode()  : returns {word[DEC_MAX_W-1:0], err}. The err flag sits in
//                 bit 0 so a caller can size-cast the result down to
//                 NUM_OUT+1 bits and keep exactly {word[NUM_OUT-1:0], err}.
// ----------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_THERM  = 1'b1
    } mode_e;

    localparam int STAT_W    = 16;
    localparam int DEC_MAX_W = 256;

    // Out-of-range selects produce an all-zero word with err set. Lines at or
    // above num_out are always zero, so truncating the result is lossless.
    function automatic logic [DEC_MAX_W:0] decode(
        input logic [31:0] sel,
        input mode_e       mode,
        input int          num_out
    );
        logic [DEC_MAX_W:0] res;
        res = '0;
        if (sel >= unsigned'(num_out)) begin
            res[0] = 1'b1;
        end else begin
            for (int i = 0; i < DEC_MAX_W; i++) begin
                if (i < num_out) begin
                    if (mode == MODE_THERM) begin
                        res[i+1] = (unsigned'(i) <= sel);
                    end else begin
                        res[i+1] = (unsigned'(i) == sel);
                    end
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_skid.sv
// ----------------------------------------------------------------------------
// decoder_skid
//   Generic 2-entry valid/ready buffer (FIFO order). Entry p0 is always the
//   head shown on the output; entry p1 only holds a word while p0 is
//   occupied. in_ready depends only on registered state and rst_n, so there
//   is no combinational in_valid -> in_ready or out_ready -> in_ready path.
//   Data registers carry no reset; only the occupancy flags are reset.
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload (head)
// ----------------------------------------------------------------------------
module decoder_skid #(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              vld_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p0;
    logic [DATA_W-1:0] data_p1;
    logic              push;
    logic              pop;

    assign in_ready  = rst_n && !vld_p1;
    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign push      = in_valid && in_ready;
    assign pop       = vld_p0 && out_ready;

    // Occupancy: empty -> p0 only -> p0 and p1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (vld_p1) begin
            // Full: no push is possible, a pop moves p1 into the head.
            if (pop) begin
                vld_p1 <= 1'b0;
            end
        end else if (vld_p0) begin
            if (push && !pop) begin
                vld_p1 <= 1'b1;
            end else if (!push && pop) begin
                vld_p0 <= 1'b0;
            end
        end else if (push) begin
            vld_p0 <= 1'b1;
        end
    end

    // Payload movement mirrors the occupancy cases above
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            if (pop) begin
                data_p0 <= data_p1;
            end
        end else if (vld_p0) begin
            if (push && pop) begin
                data_p0 <= in_data;
            end else if (push) begin
                data_p1 <= in_data;
            end
        end else if (push) begin
            data_p0 <= in_data;
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// ----------------------------------------------------------------------------
// decoder_pipe
//   Registered binary to one-hot / thermometer decoder with valid/ready on
//   both sides. Datapath: combinational decode -> 2-entry skid buffer ->
//   optional ACTIVE_LOW inversion of the word (never of out_err).
//   When the buffer is empty the word shows the idle level and out_err=0.
// Parameters
//   NUM_OUT    : number of output lines (2..DEC_MAX_W)
//   ACTIVE_LOW : 1 inverts out (idle level all-ones)
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid/in_ready       : input handshake, in_sel (binary), in_mode
//   out_valid/out_ready     : output handshake, out (word), out_err
//   stat_words/stat_errs    : saturating counters of delivered words and of
//                             delivered words with out_err set; present only
//                             when DECODER_PIPE_STATS_EN is defined
// ----------------------------------------------------------------------------
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int  NUM_OUT    = 8,
    parameter int  ACTIVE_LOW = 0,
    localparam int SEL_W      = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  mode_e              in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out,
    output logic               out_err
`ifdef DECODER_PIPE_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_words,
    output logic [STAT_W-1:0]  stat_errs
`endif
);

    localparam int PAY_W = NUM_OUT + 1;

    logic [PAY_W-1:0]   dec_p0;
    logic [PAY_W-1:0]   buf_data;
    logic               buf_valid;
    logic [NUM_OUT-1:0] word;

    // Stage p0: decode, payload = {word, err}
    assign dec_p0 = PAY_W'(decode(32'(in_sel), in_mode, NUM_OUT));

    decoder_skid #(
        .DATA_W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_p0),
        .out_valid (buf_valid),
        .out_ready (out_ready),
        .out_data  (buf_data)
    );

    // Stage p1: buffered head, forced to idle when nothing is held
    assign word      = buf_valid ? buf_data[PAY_W-1:1] : '0;
    assign out       = (ACTIVE_LOW != 0) ? ~word : word;
    assign out_err   = buf_valid && buf_data[0];
    assign out_valid = buf_valid;

`ifdef DECODER_PIPE_STATS_EN
    logic xfer;
    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_words <= '0;
            stat_errs  <= '0;
        end else if (xfer) begin
            if (stat_words != '1) begin
                stat_words <= stat_words + 1'b1;
            end
            if (out_err && (stat_errs != '1)) begin
                stat_errs <= stat_errs + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// ----------------------------------------------------------------------------
// tb_decoder_pipe
//   Three decoder_pipe instances share one input stream and one out_ready:
//   NUM_OUT=8 active-high, NUM_OUT=6 active-high (exercises out-of-range
//   selects), NUM_OUT=8 active-low. The driver pushes each accepted
//   transaction into exp_q; the monitor compares the head of exp_q against
//   every instance's output and pops it on a delivered word.
// ----------------------------------------------------------------------------
module tb_decoder_pipe;
    import decoder_pkg::*;

    typedef struct {
        logic [2:0] sel;
        mode_e      mode;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] in_sel;
    mode_e      in_mode;

    logic       ir8, ov8, err8;
    logic [7:0] out8;
    logic       ir6, ov6, err6;
    logic [5:0] out6;
    logic       ira, ova, erra;
    logic [7:0] outa;
`ifdef DECODER_PIPE_STATS_EN
    logic [15:0] sw8, se8, sw6, se6, swa, sea;
`endif

    txn_t stim_q[$];
    txn_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   pol   = 0;      // 0: out_ready=1, 1: out_ready=0, 2: random
    bit   gaps  = 1'b0;   // random idle cycles between inputs
    bit   taken = 1'b0;

    always #5 clk = ~clk;

    decoder_pipe #(.NUM_OUT(8), .ACTIVE_LOW(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
        .in_sel(in_sel), .in_mode(in_mode), .out_valid(ov8),
        .out_ready(out_ready), .out(out8), .out_err(err8)
`ifdef DECODER_PIPE_STATS_EN
        , .stat_words(sw8), .stat_errs(se8)
`endif
    );

    decoder_pipe #(.NUM_OUT(6), .ACTIVE_LOW(0)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir6),
        .in_sel(in_sel), .in_mode(in_mode), .out_valid(ov6),
        .out_ready(out_ready), .out(out6), .out_err(err6)
`ifdef DECODER_PIPE_STATS_EN
        , .stat_words(sw6), .stat_errs(se6)
`endif
    );

    decoder_pipe #(.NUM_OUT(8), .ACTIVE_LOW(1)) u_dutal (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ira),
        .in_sel(in_sel), .in_mode(in_mode), .out_valid(ova),
        .out_ready(out_ready), .out(outa), .out_err(erra)
`ifdef DECODER_PIPE_STATS_EN
        , .stat_words(swa), .stat_errs(sea)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode from the rules: one-hot = 1<<sel, thermometer =
    // (2<<sel)-1, out of range = zero word; active-low inverts within n bits.
    function automatic logic [31:0] ref_word(input txn_t t, input int n, input bit al);
        int          sel;
        logic [31:0] w;
        sel = int'(t.sel);
        if (sel >= n)                  w = 32'd0;
        else if (t.mode == MODE_THERM) w = (32'd1 << (sel + 1)) - 32'd1;
        else                           w = 32'd1 << sel;
        if (al) w = ~w & ((32'd1 << n) - 32'd1);
        return w;
    endfunction

    function automatic logic [31:0] ref_err(input txn_t t, input int n);
        return (int'(t.sel) >= n) ? 32'd1 : 32'd0;
    endfunction

    // Driver: presents stim_q in order, holds until the model says accepted.
    initial begin : driver
        logic exp_rdy;
        bit   acc;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_mode   = MODE_ONEHOT;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (taken) begin
                in_valid = 1'b0;
                taken    = 1'b0;
            end
            case (pol)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!in_valid && stim_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_sel   = stim_q[0].sel;
                in_mode  = stim_q[0].mode;
            end
            #1;
            exp_rdy = rst_n && (exp_q.size() < 2);
            check("in_ready8", 32'(ir8), 32'(exp_rdy));
            check("in_ready6", 32'(ir6), 32'(exp_rdy));
            check("in_ready_al", 32'(ira), 32'(exp_rdy));
            acc = in_valid && exp_rdy;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(stim_q.pop_front());
                taken = 1'b1;
            end else if (!rst_n) begin
                exp_q.delete();
            end
        end
    end

    // Monitor: compares every instance against the head of exp_q.
    initial begin : monitor
        txn_t t;
        bit   ev;
        forever begin
            @(negedge clk);
            #2;
            ev = (exp_q.size() != 0);
            check("out_valid8", 32'(ov8), 32'(ev));
            check("out_valid6", 32'(ov6), 32'(ev));
            check("out_valid_al", 32'(ova), 32'(ev));
            if (ev) begin
                t = exp_q[0];
                check("out8", 32'(out8), ref_word(t, 8, 1'b0));
                check("err8", 32'(err8), ref_err(t, 8));
                check("out6", 32'(out6), ref_word(t, 6, 1'b0));
                check("err6", 32'(err6), ref_err(t, 6));
                check("out_al", 32'(outa), ref_word(t, 8, 1'b1));
                check("err_al", 32'(erra), ref_err(t, 8));
                if (out_ready && rst_n) void'(exp_q.pop_front());
            end else begin
                check("idle8", 32'(out8), 32'h00);
                check("idle6", 32'(out6), 32'h00);
                check("idle_al", 32'(outa), 32'hFF);
                check("idle_err6", 32'(err6), 32'd0);
            end
        end
    end

    task automatic push(input int sel, input mode_e mode);
        txn_t t;
        t.sel  = 3'(sel);
        t.mode = mode;
        stim_q.push_back(t);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (c >= budget) begin
            n_bad++;
            $display("FAIL drain: %0d inputs and %0d outputs pending after %0d cycles",
                     stim_q.size(), exp_q.size(), c);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // One-hot sweep, back-to-back
        pol = 0;
        for (int i = 0; i < 8; i++) push(i, MODE_ONEHOT);
        drain(50);

        // Thermometer
        push(3, MODE_THERM);
        push(7, MODE_THERM);
        push(0, MODE_THERM);
        drain(30);

        // Out-of-range selects for the NUM_OUT=6 instance
        push(6, MODE_ONEHOT);
        push(7, MODE_ONEHOT);
        push(5, MODE_ONEHOT);
        push(6, MODE_THERM);
        push(5, MODE_THERM);
        drain(30);

        // Backpressure: third word must be held until space frees
        pol = 1;
        push(1, MODE_ONEHOT);
        push(2, MODE_ONEHOT);
        push(4, MODE_ONEHOT);
        repeat (6) @(negedge clk);
        pol = 0;
        drain(30);

        // Reset with two words buffered
        pol = 1;
        push(2, MODE_ONEHOT);
        push(5, MODE_THERM);
        c = 0;
        while (exp_q.size() != 2 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("buffered_before_reset", 32'(exp_q.size()), 32'd2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pol = 0;
        drain(30);

        // Randomised traffic with random backpressure and gaps
        pol  = 2;
        gaps = 1'b1;
        for (int i = 0; i < 400; i++) push(int'($urandom_range(0, 7)), mode_e'(1'($urandom_range(0, 1))));
        drain(5000);
        pol  = 0;
        gaps = 1'b0;

`ifdef DECODER_PIPE_STATS_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("stat_words_reset", 32'(sw6), 32'd0);
        check("stat_errs_reset", 32'(se6), 32'd0);
        for (int i = 0; i < 70000; i++) begin
            if (i == 10 || i == 20000 || i == 40000 || i == 60000 || i == 69990)
                push(6 + (i % 2), MODE_ONEHOT);
            else
                push(int'($urandom_range(0, 5)), mode_e'(1'($urandom_range(0, 1))));
        end
        drain(80000);
        #3;
        check("stat_words6", 32'(sw6), 32'h0000FFFF);
        check("stat_errs6", 32'(se6), 32'd5);
        check("stat_words8", 32'(sw8), 32'h0000FFFF);
        check("stat_errs8", 32'(se8), 32'd0);
        check("stat_words_al", 32'(swa), 32'h0000FFFF);
        check("stat_errs_al", 32'(sea), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
